// File: rtl/menu_logo_overlay_if.sv
// VGA stream bundle shared by the pipeline stages: timing counters, syncs, blanking and colour.
`timescale 1ns / 1ps

interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport sink (
    input hcount,
    input vcount,
    input hsync,
    input vsync,
    input hblnk,
    input vblnk,
    input rgb
  );

  modport source (
    output hcount,
    output vcount,
    output hsync,
    output vsync,
    output hblnk,
    output vblnk,
    output rgb
  );
endinterface

// File: rtl/menu_logo_overlay.sv
// Title-screen logo layer: fetches a scaled logo from a synchronous ROM, 2-clk latency.
// Build option MENU_LOGO_TRANSPARENT_EN: ROM value 12'h000 inside the logo is transparent.
`timescale 1ns / 1ps

module menu_logo_overlay #(
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 48,
  parameter int unsigned IMG_X      = 256,
  parameter int unsigned IMG_Y      = 128,
  parameter int unsigned SCALE      = 2,
  parameter int unsigned ADDR_BITS  = 14,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_game,
  input  logic [11:0]          rgb_pixel,
  output logic [ADDR_BITS-1:0] pixel_addr,
  vga_if.sink                  in,
  vga_if.source                out
);

  localparam int unsigned ScaleShift = (SCALE >= 4) ? 2 : (SCALE >= 2) ? 1 : 0;
  localparam logic [10:0] XLo = 11'(IMG_X);
  localparam logic [10:0] XHi = 11'(IMG_X + IMG_WIDTH * SCALE);
  localparam logic [10:0] YLo = 11'(IMG_Y);
  localparam logic [10:0] YHi = 11'(IMG_Y + IMG_HEIGHT * SCALE);

  // What stage 2 puts on out.rgb; the ROM word arrives only after the stage-2 edge,
  // so the choice is registered and the final mux sits behind it.
  typedef enum logic [1:0] {
    SelBlack,
    SelPass,
    SelRom,
    SelBg
  } sel_e;

  // Stage 1
  logic [10:0]          hcount1_q, vcount1_q;
  logic                 hsync1_q, vsync1_q, hblnk1_q, vblnk1_q;
  logic [11:0]          rgb1_q;
  logic                 start1_q;
  logic                 inwin1_q;
  logic [ADDR_BITS-1:0] pixel_addr_q;

  // Stage 2
  logic [10:0]          hcount2_q, vcount2_q;
  logic                 hsync2_q, vsync2_q, hblnk2_q, vblnk2_q;
  logic [11:0]          rgb2_q;
  sel_e                 sel2_q;

  logic                 inwin_d;
  logic [10:0]          dx, dy;
  logic [10:0]          col, row;
  logic [ADDR_BITS-1:0] pixel_addr_d;
  sel_e                 sel_d;
  logic [11:0]          rgb_out;

  // Window test and ROM address for the incoming pixel.
  always_comb begin
    inwin_d = (in.hcount >= XLo) && (in.hcount < XHi) &&
              (in.vcount >= YLo) && (in.vcount < YHi);
    dx = '0;
    dy = '0;
    if (inwin_d) begin
      dx = in.hcount - XLo;
      dy = in.vcount - YLo;
    end
    col = dx >> ScaleShift;
    row = dy >> ScaleShift;
    pixel_addr_d = '0;
    if (inwin_d) begin
      pixel_addr_d = ADDR_BITS'(row) * ADDR_BITS'(IMG_WIDTH) + ADDR_BITS'(col);
    end
  end

  always_comb begin
    sel_d = SelBg;
    if (hblnk1_q || vblnk1_q) begin
      sel_d = SelBlack;
    end else if (start1_q) begin
      sel_d = SelPass;
    end else if (inwin1_q) begin
      sel_d = SelRom;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount1_q    <= '0;
      vcount1_q    <= '0;
      hsync1_q     <= 1'b0;
      vsync1_q     <= 1'b0;
      hblnk1_q     <= 1'b0;
      vblnk1_q     <= 1'b0;
      rgb1_q       <= '0;
      start1_q     <= 1'b0;
      inwin1_q     <= 1'b0;
      pixel_addr_q <= '0;
      hcount2_q    <= '0;
      vcount2_q    <= '0;
      hsync2_q     <= 1'b0;
      vsync2_q     <= 1'b0;
      hblnk2_q     <= 1'b0;
      vblnk2_q     <= 1'b0;
      rgb2_q       <= '0;
      sel2_q       <= SelBlack;
    end else begin
      hcount1_q    <= in.hcount;
      vcount1_q    <= in.vcount;
      hsync1_q     <= in.hsync;
      vsync1_q     <= in.vsync;
      hblnk1_q     <= in.hblnk;
      vblnk1_q     <= in.vblnk;
      rgb1_q       <= in.rgb;
      start1_q     <= start_game;
      inwin1_q     <= inwin_d;
      pixel_addr_q <= pixel_addr_d;
      hcount2_q    <= hcount1_q;
      vcount2_q    <= vcount1_q;
      hsync2_q     <= hsync1_q;
      vsync2_q     <= vsync1_q;
      hblnk2_q     <= hblnk1_q;
      vblnk2_q     <= vblnk1_q;
      rgb2_q       <= rgb1_q;
      sel2_q       <= sel_d;
    end
  end

  always_comb begin
    rgb_out = 12'h000;
    unique case (sel2_q)
      SelBlack: rgb_out = 12'h000;
      SelPass:  rgb_out = rgb2_q;
`ifdef MENU_LOGO_TRANSPARENT_EN
      SelRom:   rgb_out = (rgb_pixel == 12'h000) ? BG_COLOR : rgb_pixel;
`else
      SelRom:   rgb_out = rgb_pixel;
`endif
      SelBg:    rgb_out = BG_COLOR;
    endcase
  end

  assign pixel_addr = pixel_addr_q;
  assign out.hcount = hcount2_q;
  assign out.vcount = vcount2_q;
  assign out.hsync  = hsync2_q;
  assign out.vsync  = vsync2_q;
  assign out.hblnk  = hblnk2_q;
  assign out.vblnk  = vblnk2_q;
  assign out.rgb    = rgb_out;

endmodule

// File: tb/tb_menu_logo_overlay.sv
// Randomized bench for menu_logo_overlay against a behavioural model with a synchronous ROM.
`timescale 1ns / 1ps

module tb_menu_logo_overlay;

  localparam int unsigned ImgW     = 256;
  localparam int unsigned ImgH     = 48;
  localparam int unsigned ImgX     = 256;
  localparam int unsigned ImgY     = 128;
  localparam int unsigned Scale    = 2;
  localparam int unsigned AddrBits = 14;
  localparam logic [11:0] Bg       = 12'h000;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start_game;
  logic [11:0]         rgb_pixel;
  logic [AddrBits-1:0] pixel_addr;

  vga_if vin ();
  vga_if vout ();

  menu_logo_overlay #(
    .IMG_WIDTH (ImgW),
    .IMG_HEIGHT(ImgH),
    .IMG_X     (ImgX),
    .IMG_Y     (ImgY),
    .SCALE     (Scale),
    .ADDR_BITS (AddrBits),
    .BG_COLOR  (Bg)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_game(start_game),
    .rgb_pixel (rgb_pixel),
    .pixel_addr(pixel_addr),
    .in        (vin),
    .out       (vout)
  );

  always #5 clk = ~clk;

  // Image ROM model: one clk of read latency, content = low 12 address bits.
  always @(posedge clk) rgb_pixel <= pixel_addr[11:0];

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        start;
  } px_t;

  int  errors = 0;
  int  checks = 0;
  int  edges  = 0;
  px_t prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_inwin(input px_t p);
    int h = int'(p.h);
    int v = int'(p.v);
    return (h >= int'(ImgX)) && (h < int'(ImgX + ImgW * Scale)) &&
           (v >= int'(ImgY)) && (v < int'(ImgY + ImgH * Scale));
  endfunction

  function automatic int ref_addr(input px_t p);
    int col, row;
    if (!ref_inwin(p)) return 0;
    col = (int'(p.h) - int'(ImgX)) / int'(Scale);
    row = (int'(p.v) - int'(ImgY)) / int'(Scale);
    return (row * int'(ImgW) + col) % (1 << AddrBits);
  endfunction

  function automatic logic [11:0] ref_rgb(input px_t p);
    int rom = ref_addr(p) % 4096;
    if (p.hb || p.vb) return 12'h000;
    if (p.start) return p.rgb;
    if (ref_inwin(p)) begin
`ifdef MENU_LOGO_TRANSPARENT_EN
      if (rom == 0) return Bg;
`endif
      return 12'(rom);
    end
    return Bg;
  endfunction

  function automatic px_t mk(input int h, input int v, input bit st, input logic [11:0] c);
    px_t p;
    p.h = 11'(h);
    p.v = 11'(v);
    p.hs = 1'b0;
    p.vs = 1'b0;
    p.hb = 1'b0;
    p.vb = 1'b0;
    p.rgb = c;
    p.start = st;
    return p;
  endfunction

  // Drive one pixel, clock it in, then check pixel_addr for it and out for the previous one.
  task automatic apply(input px_t p);
    vin.hcount = p.h;
    vin.vcount = p.v;
    vin.hsync  = p.hs;
    vin.vsync  = p.vs;
    vin.hblnk  = p.hb;
    vin.vblnk  = p.vb;
    vin.rgb    = p.rgb;
    start_game = p.start;
    @(posedge clk);
    edges++;
    #1;
    check_eq("pixel_addr", 32'(pixel_addr), 32'(ref_addr(p)));
    if (edges == 1) begin
      check_eq("first_out_hcount", 32'(vout.hcount), 32'd0);
      check_eq("first_out_vcount", 32'(vout.vcount), 32'd0);
    end else begin
      check_eq("out_hcount", 32'(vout.hcount), 32'(prev.h));
      check_eq("out_vcount", 32'(vout.vcount), 32'(prev.v));
      check_eq("out_hsync", 32'(vout.hsync), 32'(prev.hs));
      check_eq("out_vsync", 32'(vout.vsync), 32'(prev.vs));
      check_eq("out_hblnk", 32'(vout.hblnk), 32'(prev.hb));
      check_eq("out_vblnk", 32'(vout.vblnk), 32'(prev.vb));
      check_eq("out_rgb", 32'(vout.rgb), 32'(ref_rgb(prev)));
    end
    prev = p;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_hcount"}, 32'(vout.hcount), 32'd0);
    check_eq({tag, "_vcount"}, 32'(vout.vcount), 32'd0);
    check_eq({tag, "_syncs"}, 32'({vout.hsync, vout.vsync}), 32'd0);
    check_eq({tag, "_blnk"}, 32'({vout.hblnk, vout.vblnk}), 32'd0);
    check_eq({tag, "_rgb"}, 32'(vout.rgb), 32'd0);
    check_eq({tag, "_addr"}, 32'(pixel_addr), 32'd0);
  endtask

  function automatic px_t rand_px(input bit st);
    px_t p;
    if ($urandom_range(0, 1) == 0) p.h = 11'($urandom_range(240, 790));
    else p.h = 11'($urandom_range(0, 1343));
    if ($urandom_range(0, 1) == 0) p.v = 11'($urandom_range(120, 232));
    else p.v = 11'($urandom_range(0, 805));
    p.hs    = 1'($urandom_range(0, 1));
    p.vs    = 1'($urandom_range(0, 1));
    p.hb    = ($urandom_range(0, 7) == 0);
    p.vb    = ($urandom_range(0, 7) == 0);
    p.rgb   = 12'($urandom);
    p.start = st;
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit st;
    px_t p;
    int vrows[4] = '{127, 128, 223, 224};

    apply_idle();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;
    edges = 0;

    // Directed address, colour, blanking and pass-through points.
    apply(mk(256, 128, 1'b0, 12'h123));
    apply(mk(257, 128, 1'b0, 12'h123));
    apply(mk(258, 128, 1'b0, 12'h123));
    apply(mk(767, 223, 1'b0, 12'h123));
    apply(mk(768, 223, 1'b0, 12'h123));
    apply(mk(260, 130, 1'b0, 12'h456));
    apply(mk(100, 100, 1'b0, 12'h789));
    p = mk(400, 150, 1'b1, 12'hFFF);
    p.hb = 1'b1;
    apply(p);
    p = mk(400, 150, 1'b0, 12'hFFF);
    p.vb = 1'b1;
    apply(p);
    p = mk(300, 150, 1'b1, 12'hABC);
    p.hs = 1'b1;
    p.vs = 1'b1;
    apply(p);
    apply(mk(300, 150, 1'b0, 12'hABC));
    apply(mk(255, 127, 1'b0, 12'h111));

    // Window edges: rows just outside/inside top and bottom, columns across both sides.
    foreach (vrows[r]) begin
      for (int h = 250; h <= 775; h++) apply(mk(h, vrows[r], 1'b0, 12'h5A5));
    end

    st = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) st = ~st;
      apply(rand_px(st));
      if (i == 1500) begin
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("async_reset");
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1;
          check_reset_state("held_reset");
        end
        @(negedge clk);
        rst = 1'b1;
        edges = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic apply_idle();
    vin.hcount = '0;
    vin.vcount = '0;
    vin.hsync  = 1'b0;
    vin.vsync  = 1'b0;
    vin.hblnk  = 1'b0;
    vin.vblnk  = 1'b0;
    vin.rgb    = '0;
    start_game = 1'b0;
  endtask

endmodule
